// File: rtl/otter_cu_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : otter_cu_fsm
//  Purpose  : Sequencing control FSM for the multi-cycle OTTER core. Supplies
//             every state-dependent enable (PC/RF/CSR writes, memory strobes,
//             interrupt entry, mret) and counts retired instructions. Datapath
//             selects come from the separate combinational decoder.
//  Ports    : clk, rst_n (sync, active-low)
//             opcode[6:0], func3[2:0]  - currently held instruction fields
//             imem_ready, dmem_ready   - memory completion handshakes
//             intr, mie                - interrupt request / global enable
//             rst_core, imem_rden, dmem_rden, dmem_we, pc_write, rf_we,
//             csr_we, int_taken, mret_exec, illegal - control outputs
//             instret[INSTRET_W-1:0]   - retired-instruction counter
//  Revision : 1.0 - initial release
// ============================================================================
module otter_cu_fsm #(
    parameter int INSTRET_W = 32,
    parameter bit INTR_EN   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode,
    input  logic [2:0]           func3,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    input  logic                 intr,
    input  logic                 mie,
    output logic                 rst_core,
    output logic                 imem_rden,
    output logic                 dmem_rden,
    output logic                 dmem_we,
    output logic                 pc_write,
    output logic                 rf_we,
    output logic                 csr_we,
    output logic                 int_taken,
    output logic                 mret_exec,
    output logic                 illegal,
    output logic [INSTRET_W-1:0] instret
);

    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_WB    = 3'd3;
    localparam logic [2:0] S_INTR  = 3'd4;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [2:0]           r_state;
    logic [2:0]           w_next_state;
    logic [INSTRET_W-1:0] r_instret;
    logic                 w_retire;
    logic                 w_take_intr;

    // Interrupts are only ever considered at a retire boundary.
    assign w_take_intr = INTR_EN && intr && mie;

    // ------------------------------------------------------------------
    // State register and retired-instruction counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_INIT;
            r_instret <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_retire) begin
                r_instret <= r_instret + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic (also produces the retire qualifier)
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_retire     = 1'b0;
        case (r_state)
            S_INIT:  w_next_state = S_FETCH;
            S_FETCH: if (imem_ready) w_next_state = S_EXEC;
            S_EXEC: begin
                if (opcode == OP_LOAD) begin
                    w_next_state = S_WB;
                end else if (opcode == OP_STORE) begin
                    w_retire = dmem_ready;
                end else begin
                    // Every other opcode, including unrecognised ones, retires here.
                    w_retire = 1'b1;
                end
            end
            S_WB:    w_retire = dmem_ready;
            S_INTR:  w_next_state = S_FETCH;
            default: w_next_state = S_INIT;
        endcase
        if (w_retire) begin
            w_next_state = w_take_intr ? S_INTR : S_FETCH;
        end
    end

    // ------------------------------------------------------------------
    // Output logic: combinational from state and inputs
    // ------------------------------------------------------------------
    always_comb begin
        rst_core  = 1'b0;
        imem_rden = 1'b0;
        dmem_rden = 1'b0;
        dmem_we   = 1'b0;
        pc_write  = 1'b0;
        rf_we     = 1'b0;
        csr_we    = 1'b0;
        int_taken = 1'b0;
        mret_exec = 1'b0;
        illegal   = 1'b0;
        if (!rst_n) begin
            // Reset overrides the current state immediately so an in-flight
            // load/store drops its strobes in the reset cycle itself.
            rst_core = 1'b1;
        end else begin
            case (r_state)
                S_INIT:  rst_core  = 1'b1;
                S_FETCH: imem_rden = 1'b1;
                S_EXEC: begin
                    case (opcode)
                        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_REG: begin
                            pc_write = 1'b1;
                            rf_we    = 1'b1;
                        end
                        OP_BRANCH: pc_write = 1'b1;
                        OP_LOAD:   dmem_rden = 1'b1;
                        OP_STORE: begin
                            dmem_we  = 1'b1;
                            pc_write = dmem_ready;
                        end
                        OP_SYSTEM: begin
                            pc_write = 1'b1;
                            if (func3 != 3'b000) begin
                                rf_we  = 1'b1;
                                csr_we = 1'b1;
                            end else begin
                                mret_exec = 1'b1;
                            end
                        end
                        default: begin
                            illegal  = 1'b1;
                            pc_write = 1'b1;
                        end
                    endcase
                end
                S_WB: begin
                    dmem_rden = 1'b1;
                    rf_we     = dmem_ready;
                    pc_write  = dmem_ready;
                end
                S_INTR: begin
                    int_taken = 1'b1;
                    pc_write  = 1'b1;
                end
                default: rst_core = 1'b1;
            endcase
        end
    end

    // Counter reads as zero for the whole reset cycle, not just after the edge.
    assign instret = rst_n ? r_instret : '0;

endmodule
`default_nettype wire

// File: tb/tb_otter_cu_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_otter_cu_fsm
//  Purpose  : Self-checking bench for otter_cu_fsm. A cycle-by-cycle table of
//             inputs and expected control outputs is driven in order; each
//             expectation is queued as it is driven and compared when the
//             outputs are sampled. A counter-wrap sequence follows the table.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_otter_cu_fsm;

    localparam int CW = 4;

    localparam logic [6:0] ADD   = 7'b0110011;
    localparam logic [6:0] ADDI  = 7'b0010011;
    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;
    localparam logic [6:0] BR    = 7'b1100011;
    localparam logic [6:0] SYS   = 7'b1110011;
    localparam logic [6:0] BAD   = 7'b1111111;

    // Control output bit positions: {rst_core, imem_rden, dmem_rden, dmem_we,
    // pc_write, rf_we, csr_we, int_taken, mret_exec, illegal}
    localparam logic [9:0] RC = 10'b1000000000;
    localparam logic [9:0] IR = 10'b0100000000;
    localparam logic [9:0] DR = 10'b0010000000;
    localparam logic [9:0] DW = 10'b0001000000;
    localparam logic [9:0] PW = 10'b0000100000;
    localparam logic [9:0] RW = 10'b0000010000;
    localparam logic [9:0] CS = 10'b0000001000;
    localparam logic [9:0] IT = 10'b0000000100;
    localparam logic [9:0] MR = 10'b0000000010;
    localparam logic [9:0] IL = 10'b0000000001;

    typedef struct {
        logic          rst_n;
        logic [6:0]    op;
        logic [2:0]    f3;
        logic          ir;
        logic          dr;
        logic          intr;
        logic          mie;
        logic [9:0]    exp_ctl;
        logic [CW-1:0] exp_cnt;
    } vec_t;

    typedef struct {
        int            id;
        logic [9:0]    ctl;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [6:0]    opcode;
    logic [2:0]    func3;
    logic          imem_ready, dmem_ready, intr, mie;
    logic          rst_core, imem_rden, dmem_rden, dmem_we, pc_write;
    logic          rf_we, csr_we, int_taken, mret_exec, illegal;
    logic [CW-1:0] instret;

    int checks = 0;
    int errors = 0;
    int step_id = 0;

    vec_t tbl[$];
    exp_t sb[$];

    otter_cu_fsm #(.INSTRET_W(CW), .INTR_EN(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .func3      (func3),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .intr       (intr),
        .mie        (mie),
        .rst_core   (rst_core),
        .imem_rden  (imem_rden),
        .dmem_rden  (dmem_rden),
        .dmem_we    (dmem_we),
        .pc_write   (pc_write),
        .rf_we      (rf_we),
        .csr_we     (csr_we),
        .int_taken  (int_taken),
        .mret_exec  (mret_exec),
        .illegal    (illegal),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [6:0] o, input logic [2:0] f,
                                input logic i_r, input logic d_r, input logic it,
                                input logic m, input logic [9:0] c, input logic [CW-1:0] n);
        vec_t v;
        v.rst_n = r;   v.op = o;     v.f3 = f;      v.ir = i_r; v.dr = d_r;
        v.intr  = it;  v.mie = m;    v.exp_ctl = c; v.exp_cnt = n;
        return v;
    endfunction

    // Drive one cycle of stimulus just after the rising edge, queue its
    // expectation, then sample and compare on the falling edge.
    task automatic step(input vec_t v);
        exp_t e;
        exp_t g;
        logic [9:0] got;
        @(posedge clk);
        #1;
        rst_n = v.rst_n; opcode = v.op; func3 = v.f3;
        imem_ready = v.ir; dmem_ready = v.dr; intr = v.intr; mie = v.mie;
        e.id = step_id; e.ctl = v.exp_ctl; e.cnt = v.exp_cnt;
        sb.push_back(e);
        step_id++;
        @(negedge clk);
        got = {rst_core, imem_rden, dmem_rden, dmem_we, pc_write,
               rf_we, csr_we, int_taken, mret_exec, illegal};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got ctl=%b cnt=%0d, required a queued expectation", got, instret);
        end else begin
            g = sb.pop_front();
            if (got !== g.ctl || instret !== g.cnt) begin
                errors++;
                $display("FAIL cycle%0d: got ctl=%b instret=%0d, required ctl=%b instret=%0d",
                         g.id, got, instret, g.ctl, g.cnt);
            end
        end
    endtask

    initial begin
        logic [CW-1:0] cnt;
        rst_n = 1'b0; opcode = '0; func3 = '0;
        imem_ready = 1'b0; dmem_ready = 1'b0; intr = 1'b0; mie = 1'b0;

        //             rst  op     f3    ir dr it mie  ctl          cnt
        tbl.push_back(mk(0, LOAD,  3'd0, 1, 0, 0, 0, RC,          0));  // reset from arbitrary state
        tbl.push_back(mk(0, LOAD,  3'd0, 1, 0, 0, 0, RC,          0));
        tbl.push_back(mk(1, ADD,   3'd0, 1, 0, 0, 0, RC,          0));  // INIT
        tbl.push_back(mk(1, ADD,   3'd0, 1, 0, 0, 0, IR,          0));  // FETCH add
        tbl.push_back(mk(1, ADD,   3'd0, 1, 0, 0, 0, PW|RW,       0));  // EXEC add
        tbl.push_back(mk(1, ADDI,  3'd0, 1, 0, 0, 0, IR,          1));
        tbl.push_back(mk(1, ADDI,  3'd0, 1, 0, 0, 0, PW|RW,       1));
        tbl.push_back(mk(1, LOAD,  3'd2, 0, 0, 0, 0, IR,          2));  // fetch wait
        tbl.push_back(mk(1, LOAD,  3'd2, 1, 0, 0, 0, IR,          2));
        tbl.push_back(mk(1, LOAD,  3'd2, 1, 0, 0, 0, DR,          2));  // EXEC load
        tbl.push_back(mk(1, LOAD,  3'd2, 1, 0, 0, 0, DR,          2));  // WB wait x3
        tbl.push_back(mk(1, LOAD,  3'd2, 1, 0, 0, 0, DR,          2));
        tbl.push_back(mk(1, LOAD,  3'd2, 1, 0, 0, 0, DR,          2));
        tbl.push_back(mk(1, LOAD,  3'd2, 1, 1, 0, 0, DR|RW|PW,    2));  // WB done
        tbl.push_back(mk(1, STORE, 3'd2, 1, 0, 0, 0, IR,          3));
        tbl.push_back(mk(1, STORE, 3'd2, 1, 0, 0, 0, DW,          3));
        tbl.push_back(mk(1, STORE, 3'd2, 1, 0, 0, 0, DW,          3));
        tbl.push_back(mk(1, STORE, 3'd2, 1, 1, 0, 0, DW|PW,       3));
        tbl.push_back(mk(1, BR,    3'd0, 1, 0, 0, 0, IR,          4));
        tbl.push_back(mk(1, BR,    3'd0, 1, 0, 0, 0, PW,          4));
        tbl.push_back(mk(1, ADD,   3'd0, 1, 0, 0, 0, IR,          5));
        tbl.push_back(mk(1, ADD,   3'd0, 1, 0, 1, 1, PW|RW,       5));  // retire with intr+mie
        tbl.push_back(mk(1, ADD,   3'd0, 1, 0, 1, 1, IT|PW,       6));  // INTR
        tbl.push_back(mk(1, ADD,   3'd0, 1, 0, 0, 0, IR,          6));
        tbl.push_back(mk(1, ADD,   3'd0, 1, 0, 1, 0, PW|RW,       6));  // mie=0: no INTR
        tbl.push_back(mk(1, BAD,   3'd0, 1, 0, 1, 1, IR,          7));  // intr outside retire
        tbl.push_back(mk(1, BAD,   3'd0, 1, 0, 0, 1, IL|PW,       7));  // illegal opcode
        tbl.push_back(mk(1, SYS,   3'd1, 1, 0, 0, 0, IR,          8));
        tbl.push_back(mk(1, SYS,   3'd1, 1, 0, 0, 0, RW|CS|PW,    8));  // CSR op
        tbl.push_back(mk(1, SYS,   3'd0, 1, 0, 0, 0, IR,          9));
        tbl.push_back(mk(1, SYS,   3'd0, 1, 0, 1, 1, MR|PW,       9));  // mret with intr
        tbl.push_back(mk(1, LOAD,  3'd0, 1, 0, 0, 0, IT|PW,      10));
        tbl.push_back(mk(1, LOAD,  3'd0, 1, 0, 0, 0, IR,         10));
        tbl.push_back(mk(1, LOAD,  3'd0, 1, 0, 0, 0, DR,         10));
        tbl.push_back(mk(1, LOAD,  3'd0, 1, 0, 0, 0, DR,         10));  // WB wait
        tbl.push_back(mk(0, LOAD,  3'd0, 1, 1, 0, 0, RC,          0));  // reset mid-load
        tbl.push_back(mk(1, LOAD,  3'd0, 0, 0, 0, 0, RC,          0));  // INIT
        tbl.push_back(mk(1, ADD,   3'd0, 0, 0, 0, 0, IR,          0));

        foreach (tbl[i]) step(tbl[i]);

        // Counter wrap: sixteen two-cycle retirements bring the counter
        // through all-ones back to zero.
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            step(mk(1, ADD, 3'd0, 1, 0, 0, 0, IR, cnt));
            step(mk(1, ADD, 3'd0, 1, 0, 0, 0, PW|RW, cnt));
            cnt = cnt + 1'b1;
        end
        step(mk(1, ADD, 3'd0, 0, 0, 0, 0, IR, 4'd0));

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, required 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/otter_cu_fsm.md
Name: otter_cu_fsm

Overview:
- Sequencing control FSM for the multi-cycle OTTER core.
- Sits beside the combinational control decoder, which supplies the datapath selects. This block supplies all state-dependent enables: PC write, register-file write, memory read/write strobes, CSR write, interrupt entry and mret.
- Consumes the fetched instruction's opcode/func3 plus memory-ready and interrupt handshakes.
- Maintains a retired-instruction counter.

Parameters:
INSTRET_W, 32, width of retired-instruction counter (wraps modulo 2^INSTRET_W)
INTR_EN, 1, 0 = interrupt input ignored and INTR state unreachable

Ports:
clk  in  1  core clock, all state on rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising clk
opcode  in  7  instruction[6:0] of the currently held instruction
func3  in  3  instruction[14:12]
imem_ready  in  1  instruction memory has valid data this cycle
dmem_ready  in  1  data memory completes the current read/write this cycle
intr  in  1  external interrupt request, level
mie  in  1  CSR global interrupt enable
rst_core  out  1  resets PC/datapath registers
imem_rden  out  1  instruction fetch strobe
dmem_rden  out  1  data read strobe
dmem_we  out  1  data write strobe
pc_write  out  1  PC register load enable
rf_we  out  1  register-file write enable
csr_we  out  1  CSR write enable
int_taken  out  1  interrupt entry; decoder/CSR save mepc and vector
mret_exec  out  1  mret retiring
illegal  out  1  one-cycle pulse on unrecognised opcode
instret  out  INSTRET_W  retired-instruction count

Behaviour:
- States: INIT, FETCH, EXEC, WB, INTR.
- Outputs are combinational from state plus inputs; all outputs not listed for a state are 0.
- rst_n=0 at an edge: state<=INIT, instret<=0, regardless of current state (a pending load/store is abandoned and no strobe is held).
- Reset values: during reset and in INIT, rst_core=1, all other strobes 0, instret=0.
- INIT: rst_core=1; next state FETCH unconditionally.
- FETCH: imem_rden=1; stay while imem_ready=0; go to EXEC on imem_ready=1.
- EXEC, by opcode (LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP_IMM 0010011, OP_REG 0110011, SYSTEM 1110011):
  - LUI/AUIPC/JAL/JALR/OP_IMM/OP_REG: pc_write=1, rf_we=1; retire.
  - BRANCH: pc_write=1, rf_we=0; retire.
  - LOAD: dmem_rden=1; next WB. No pc_write here.
  - STORE: dmem_we=1 held until dmem_ready=1. In that cycle pc_write=1 and retire; otherwise stay in EXEC.
  - SYSTEM with func3!=000 (CSR ops): rf_we=1, csr_we=1, pc_write=1; retire.
  - SYSTEM with func3=000 (mret): mret_exec=1, pc_write=1; retire.
  - Any other opcode: illegal=1, pc_write=1, no other writes; counts as retire (treated as NOP).
- WB: dmem_rden=1 held. Stay while dmem_ready=0. On dmem_ready=1: rf_we=1, pc_write=1; retire.
- Retire cycle:
  - instret<=instret+1, wrapping all-ones to 0.
  - Next state is INTR if INTR_EN=1 and intr=1 and mie=1 in that same cycle; else FETCH.
- INTR: int_taken=1, pc_write=1, one cycle, then FETCH. Not counted in instret.
- intr is level-sampled only at retire; intr asserted and dropped entirely within a non-retire cycle is not taken.
- mret retire with intr=1 and mie=1 goes to INTR (mie value is as presented at that cycle).
- Minimum CPI: 2 for ALU/branch/jump (FETCH+EXEC), 3 for load (FETCH+EXEC+WB), each plus memory wait cycles.

Test Plan:
- Reset: rst_n=0 for 2 cycles from arbitrary state -> rst_core=1, all strobes 0, instret=0. rst_n=1 -> one INIT cycle then imem_rden=1.
- ADD then ADDI, imem_ready=1 -> each instruction 2 cycles, rf_we and pc_write high exactly in EXEC cycle, instret 0->1->2.
- LOAD with dmem_ready low for 3 WB cycles -> dmem_rden high in EXEC+4 WB cycles, rf_we/pc_write only on the 4th WB cycle, instret +1.
- STORE with dmem_ready delayed 2 cycles; BRANCH -> dmem_we held 3 EXEC cycles, rf_we never asserted; branch pc_write=1, rf_we=0.
- Interrupt: intr=1, mie=1 at OP_REG retire -> next cycle INTR with int_taken=1, pc_write=1, then FETCH. Same with mie=0 -> no INTR. Opcode 1111111 -> illegal pulse, instret increments.
- Reset mid-load (rst_n=0 in WB) -> no rf_we, INIT next. Preloaded instret=all-ones then retire -> instret=0.
